voice_mixer: RTL and testbench
==============================

// Module: voice_mixer
// PURPOSE
//  Polyphonic square-wave tone generator and mixer feeding the delta-sigma DAC stage.
//  Note on/off commands set per-voice phase increments; once per sample period the block
//  time-multiplexes over all voices, sums their outputs and emits one DEPTH-bit sample.
//  sample_out drives the DAC's data_in; sample_valid drives the DAC's enable.
// PARAMETERS
//  DEPTH      8    sample width; must match the downstream DAC DEPTH
//  VOICES     8    voice count; power of 2, 2..2**(DEPTH-1)
//  PHASE_W    24   phase-accumulator width per voice
//  SAMPLE_DIV 256  clk cycles per sample period; must be >= VOICES+2
// PORTS
//  clk           in   1                 system clock
//  reset         in   1                 synchronous reset, active-high
//  cmd_valid     in   1                 command present
//  cmd_ready     out  1                 command accepted when valid & ready
//  cmd_on        in   1                 1 = note on, 0 = note off
//  cmd_voice     in   $clog2(VOICES)    target voice index
//  cmd_inc       in   PHASE_W           phase increment per sample (ignored on note off)
//  sample_out    out  DEPTH             mixed sample, held between strobes
//  sample_valid  out  1                 1-cycle strobe when sample_out updates
// BEHAVIOUR
//  - Slot counter cnt: 0..SAMPLE_DIV-1, wraps to 0; cnt=0 starts a sample period.
//  - AMP = 2**(DEPTH-$clog2(VOICES)).
//  - Scan: for cnt=i in 0..VOICES-1, process voice i; contribution c_i uses the phase before update.
//  - Contribution: inactive voice -> AMP/2; active voice -> phase MSB ? AMP-1 : 0.
//  - Phase update: an active voice does phase += inc, mod 2**PHASE_W; wrap-around is silent.
//  - Accumulator width: DEPTH bits; maximum sum VOICES*(AMP-1) < 2**DEPTH, so no overflow.
//  - cnt=VOICES: sample_out <= acc, sample_valid=1 for that cycle only; acc cleared to 0.
//  - Silence = VOICES*AMP/2 = 2**(DEPTH-1).
//  - cmd_ready = (cnt >= VOICES+1). Per-voice state never changes during the scan or output cycle.
//  - Note on: active=1, inc=cmd_inc, phase=0 (retrigger even if already active).
//  - Note off: active=0, phase=0. Note off on an idle voice is a no-op.
//  - At most one command per cycle; commands to different voices in one period all apply.
//  - Latency: a command accepted in period k first affects the sample strobed in period k+1
//    (cnt=VOICES).
//  - cmd_valid may be held while cmd_ready=0; the command is accepted exactly once, at the first
//    cycle with ready high.
//  - Reset values: cnt=0, all voices inactive, phase=0, inc=0, acc=0,
//    sample_out=2**(DEPTH-1), sample_valid=0, cmd_ready=0.
//  - Reset mid-scan discards the partial sum; the first strobe comes VOICES cycles after reset
//    deasserts.
// CONFIGURATION
//  VOICE_MIXER_SAW_EN defined: an active voice contributes the sawtooth phase[PHASE_W-1 -: DEPTH-$clog2(VOICES)]
//    (range 0..AMP-1) instead of the square. Inactive voices, timing and handshake are unchanged.
//  Undefined: square only; no sawtooth logic is synthesised.
// STRUCTURE
//  - synth_pkg: voice_cmd_t struct {on, voice, inc}; function amp(DEPTH,VOICES); SILENCE constant.
//  - Sub-module sample_tick: cnt counter plus decoded scan_en, slot index, out_strobe and
//    cmd_window outputs.
//  - Per-voice active/inc/phase are held in register arrays indexed by slot (LUT-RAM friendly).
// TESTING  (DEPTH=8, VOICES=8, PHASE_W=24, SAMPLE_DIV=256, AMP=32)
//  1. Reset, then no commands -> sample_valid at cycles 8, 264, 520, ...; sample_out=128;
//     cmd_ready low for cnt 0..8.
//  2. Note on, voice 0, inc=2**22 -> next samples 112,112,143,143, repeating with period 4.
//  3. Then note off, voice 0 -> next sample 128 and every later sample 128.
//  4. All 8 voices note on, inc=2**23 -> samples alternate 0,248,0,248.
//  5. cmd_valid held from cnt=2 -> accepted once at cnt=9; cmd_ready low for cnt 0..8 of each period.
//  6. Reset asserted at cnt=4 with voices active -> sample_out=128, no strobe during reset;
//     next strobe 8 cycles after release.
//  7. VOICE_MIXER_SAW_EN, voice 0 inc=2**21 -> samples 112,116,120,...,140,112.

Source files
------------

// File: rtl/voice_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : voice_mixer_pkg
// Brief    : Shared types and amplitude helpers for the voice mixer.
// Revision : 1.0
// ============================================================================
package voice_mixer_pkg;

  typedef struct packed {
    logic        on;
    logic [7:0]  voice;
    logic [31:0] inc;
  } voice_cmd_t;

  // Per-voice full-scale step: VOICES voices at this amplitude fill DEPTH bits.
  function automatic int amp(input int depth, input int voices);
    return 1 << (depth - $clog2(voices));
  endfunction

  function automatic int silence(input int depth);
    return 1 << (depth - 1);
  endfunction

  localparam int c_default_depth = 8;
  localparam int c_silence       = 1 << (c_default_depth - 1);

endpackage
`default_nettype wire

// File: rtl/voice_mixer_sample_tick.sv
`default_nettype none
// ============================================================================
// Module   : sample_tick
// Brief    : Sample-period slot counter with scan/strobe/command-window decode.
// Revision : 1.0
// ============================================================================
module sample_tick #(
  parameter int VOICES     = 8,
  parameter int SAMPLE_DIV = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      o_scan_en,
  output logic [$clog2(VOICES)-1:0] o_slot,
  output logic                      o_out_strobe,
  output logic                      o_cmd_window
);

  localparam int c_cw = $clog2(SAMPLE_DIV);
  localparam int c_vw = $clog2(VOICES);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cw'(SAMPLE_DIV - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

  assign o_scan_en    = (r_cnt <  c_cw'(VOICES));
  assign o_slot       = r_cnt[c_vw-1:0];
  assign o_out_strobe = (r_cnt == c_cw'(VOICES));
  assign o_cmd_window = (r_cnt >  c_cw'(VOICES));

endmodule
`default_nettype wire

// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : voice_mixer
// Brief    : Polyphonic square-wave tone generator and mixer for the DAC stage.
// Config   : define VOICE_MIXER_SAW_EN for sawtooth voices instead of square.
// Revision : 1.0
// ============================================================================
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int VOICES     = 8,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_DIV = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_on,
  input  logic [$clog2(VOICES)-1:0] cmd_voice,
  input  logic [PHASE_W-1:0]        cmd_inc,
  output logic [DEPTH-1:0]          sample_out,
  output logic                      sample_valid
);

  localparam int               c_vw      = $clog2(VOICES);
  localparam logic [DEPTH-1:0] c_silence = DEPTH'(silence(DEPTH));
  localparam logic [DEPTH-1:0] c_half    = DEPTH'(amp(DEPTH, VOICES) / 2);
`ifdef VOICE_MIXER_SAW_EN
  localparam int               c_aw      = DEPTH - c_vw;
`else
  localparam logic [DEPTH-1:0] c_amp_m1  = DEPTH'(amp(DEPTH, VOICES) - 1);
`endif

  logic                w_scan_en;
  logic [c_vw-1:0]     w_slot;
  logic                w_out_strobe;
  logic                w_cmd_window;
  logic                w_last_slot;
  logic                w_cmd_fire;
  logic [DEPTH-1:0]    w_contrib;
  logic [DEPTH-1:0]    w_acc_next;

  logic                r_active [VOICES];
  logic [PHASE_W-1:0]  r_inc    [VOICES];
  logic [PHASE_W-1:0]  r_phase  [VOICES];
  logic [DEPTH-1:0]    r_acc;

  sample_tick #(
    .VOICES     (VOICES),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk          (clk),
    .rst          (reset),
    .o_scan_en    (w_scan_en),
    .o_slot       (w_slot),
    .o_out_strobe (w_out_strobe),
    .o_cmd_window (w_cmd_window)
  );

  assign cmd_ready    = w_cmd_window;
  assign w_cmd_fire   = cmd_valid && w_cmd_window;
  // The strobe cycle directly follows the last scan slot, whose edge loads sample_out.
  assign sample_valid = w_out_strobe;
  assign w_last_slot  = w_scan_en && (w_slot == c_vw'(VOICES - 1));

  always_comb begin
    w_contrib = c_half;
    if (r_active[w_slot]) begin
`ifdef VOICE_MIXER_SAW_EN
      w_contrib = DEPTH'(r_phase[w_slot][PHASE_W-1 -: c_aw]);
`else
      w_contrib = r_phase[w_slot][PHASE_W-1] ? c_amp_m1 : '0;
`endif
    end
  end

  assign w_acc_next = r_acc + w_contrib;

  // Scan slots and the command window never overlap, so voice writes cannot collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      sample_out <= c_silence;
      for (int v = 0; v < VOICES; v++) begin
        r_active[v] <= 1'b0;
        r_inc[v]    <= '0;
        r_phase[v]  <= '0;
      end
    end else begin
      if (w_scan_en) begin
        if (w_last_slot) begin
          sample_out <= w_acc_next;
          r_acc      <= '0;
        end else begin
          r_acc      <= w_acc_next;
        end
        if (r_active[w_slot]) begin
          r_phase[w_slot] <= r_phase[w_slot] + r_inc[w_slot];
        end
      end
      if (w_cmd_fire) begin
        r_active[cmd_voice] <= cmd_on;
        r_phase[cmd_voice]  <= '0;
        if (cmd_on) begin
          r_inc[cmd_voice] <= cmd_inc;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_mixer
// Brief    : Self-checking bench for voice_mixer against a per-period tone model.
// Revision : 1.0
// ============================================================================
module tb_voice_mixer;
  import voice_mixer_pkg::*;

  localparam int DEPTH      = 8;
  localparam int VOICES     = 8;
  localparam int PHASE_W    = 24;
  localparam int SAMPLE_DIV = 256;
  localparam int AMP        = 1 << (DEPTH - 3);
  localparam int PMOD       = 1 << PHASE_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_on = 1'b0;
  logic [2:0]        cmd_voice = '0;
  logic [PHASE_W-1:0] cmd_inc = '0;
  logic              cmd_ready;
  logic [DEPTH-1:0]  sample_out;
  logic              sample_valid;

  voice_mixer #(
    .DEPTH(DEPTH), .VOICES(VOICES), .PHASE_W(PHASE_W), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_on(cmd_on), .cmd_voice(cmd_voice), .cmd_inc(cmd_inc),
    .sample_out(sample_out), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int k = 0;
  int exp_sample = 128;
  int held = 128;
  int m_active [VOICES];
  int m_inc    [VOICES];
  int m_phase  [VOICES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < VOICES; v++) begin
      m_active[v] = 0; m_inc[v] = 0; m_phase[v] = 0;
    end
  endtask

  // One sample period: sum every voice's level, then advance active phases.
  task automatic model_period();
    int sum = 0;
    for (int v = 0; v < VOICES; v++) begin
      if (m_active[v] == 0) sum += AMP / 2;
`ifdef VOICE_MIXER_SAW_EN
      else sum += m_phase[v] / (PMOD / AMP);
`else
      else sum += (m_phase[v] >= PMOD / 2) ? AMP - 1 : 0;
`endif
    end
    exp_sample = sum;
    for (int v = 0; v < VOICES; v++)
      if (m_active[v] != 0) m_phase[v] = (m_phase[v] + m_inc[v]) % PMOD;
  endtask

  task automatic model_cmd(input voice_cmd_t c);
    int v = int'(c.voice);
    m_active[v] = c.on ? 1 : 0;
    m_phase[v]  = 0;
    if (c.on) m_inc[v] = int'(c.inc);
  endtask

  task automatic step(output bit acc);
    voice_cmd_t c;
    int slot = k % SAMPLE_DIV;
    acc = 1'b0;
    if (slot == 0) model_period();
    if (cmd_valid && slot >= VOICES + 1) begin
      c.on = cmd_on; c.voice = 8'(cmd_voice); c.inc = 32'(cmd_inc);
      model_cmd(c);
      acc = 1'b1;
    end
    @(posedge clk); k++; @(negedge clk);
    slot = k % SAMPLE_DIV;
    if (slot == VOICES) held = exp_sample;
    check("cmd_ready", 32'(cmd_ready), 32'(slot >= VOICES + 1));
    check("sample_valid", 32'(sample_valid), 32'(slot == VOICES));
    check("sample_out", 32'(sample_out), 32'(held));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_sample", 32'(sample_out), 32'd128);
      check("rst_ready", 32'(cmd_ready), 32'd0);
    end
    reset = 1'b0;
    k = 0; held = 128;
    model_clear();
  endtask

  task automatic run_to_strobe(output int s);
    bit a;
    bit seen = 1'b0;
    s = -1;
    for (int t = 0; t < SAMPLE_DIV + 8 && !seen; t++) begin
      step(a);
      if (sample_valid === 1'b1) begin seen = 1'b1; s = int'(sample_out); end
    end
    check("strobe_timeout", 32'(seen), 32'd1);
  endtask

  task automatic issue(input bit on, input int v, input int inc);
    bit acc = 1'b0;
    cmd_valid = 1'b1; cmd_on = on; cmd_voice = 3'(v); cmd_inc = PHASE_W'(inc);
    for (int t = 0; t < SAMPLE_DIV + 8 && !acc; t++) step(acc);
    cmd_valid = 1'b0;
    check("cmd_accept_timeout", 32'(acc), 32'd1);
  endtask

  initial begin
    int s;
    bit a;
    int t2 [5] = '{112, 112, 143, 143, 112};
    int t4 [4] = '{0, 248, 0, 248};
    model_clear();

    // Reset and idle silence
    do_reset(3);
    run_to_strobe(s);
    check("first_strobe_cycle", 32'(k), 32'd8);
    check("idle_sample", 32'(s), 32'd128);
    run_to_strobe(s);
    check("second_strobe_cycle", 32'(k), 32'd264);

    // Single square voice
    issue(1'b1, 0, 1 << 22);
    for (int i = 0; i < 5; i++) begin
      run_to_strobe(s);
      check("square_v0", 32'(s), 32'(t2[i]));
    end

    // Note off returns to silence
    issue(1'b0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      run_to_strobe(s);
      check("note_off", 32'(s), 32'd128);
    end

    // All voices in phase
    for (int v = 0; v < VOICES; v++) issue(1'b1, v, 1 << 23);
    for (int i = 0; i < 4; i++) begin
      run_to_strobe(s);
      check("all_voices", 32'(s), 32'(t4[i]));
    end

    // Command held while not ready
    for (int t = 0; t < SAMPLE_DIV && (k % SAMPLE_DIV) != 2; t++) step(a);
    issue(1'b1, 3, 1 << 22);
    for (int i = 0; i < 3; i++) run_to_strobe(s);

    // Reset in the middle of a scan
    for (int t = 0; t < SAMPLE_DIV && (k % SAMPLE_DIV) != 4; t++) step(a);
    do_reset(2);
    run_to_strobe(s);
    check("post_reset_latency", 32'(k), 32'd8);
    check("post_reset_sample", 32'(s), 32'd128);

`ifdef VOICE_MIXER_SAW_EN
    issue(1'b1, 0, 1 << 21);
    for (int i = 0; i < 9; i++) begin
      run_to_strobe(s);
      check("saw_v0", 32'(s), 32'(i < 8 ? 112 + 4 * i : 112));
    end
`endif

    // Randomized commands against the model
    for (int p = 0; p < 24; p++) begin
      int n = int'($urandom_range(0, 3));
      for (int j = 0; j < n; j++) begin
        int idle = int'($urandom_range(0, 20));
        int inc;
        for (int t = 0; t < idle; t++) step(a);
        if ($urandom_range(0, 3) == 0) inc = 1 << $urandom_range(18, 23);
        else inc = int'($urandom & 32'h00FF_FFFF);
        issue($urandom_range(0, 3) != 0, int'($urandom_range(0, VOICES - 1)), inc);
      end
      run_to_strobe(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
